// File: rtl/ysyx_220053_idu.sv
// Decode stage for the ysyx_220053 RV64I core: turns integer-computational
// instructions into an ALU op/operand bundle held in a one-entry output register.
module ysyx_220053_idu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_word,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPW     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMMW = 7'b0011011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;

  assign opcode   = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign imm_i    = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u    = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'h000};
  assign shamt6   = {{(XLEN-6){1'b0}}, in_inst[25:20]};
  assign shamt5   = {{(XLEN-5){1'b0}}, in_inst[24:20]};

  logic            legal;
  logic [3:0]      dec_aluop;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_word;
  logic [3:0]      aluop_next;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic            word_next;
  logic            wen_next;

  always_comb begin
    legal     = 1'b0;
    dec_aluop = 4'b0000;
    dec_a     = '0;
    dec_b     = '0;
    dec_word  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        if (funct7 == 7'b0000000) begin
          legal     = 1'b1;
          dec_aluop = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal     = 1'b1;
          dec_aluop = {1'b1, funct3};
        end
      end
      OPC_OP_IMM: begin
        dec_a = rs1_data;
        case (funct3)
          3'b001: begin
            legal     = (in_inst[31:26] == 6'b000000);
            dec_aluop = 4'b0001;
            dec_b     = shamt6;
          end
          3'b101: begin
            legal     = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
            dec_aluop = {in_inst[30], 3'b101};
            dec_b     = shamt6;
          end
          default: begin
            legal     = 1'b1;
            dec_aluop = {1'b0, funct3};
            dec_b     = imm_i;
          end
        endcase
      end
      OPC_OPW: begin
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        dec_word = 1'b1;
        if (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) begin
          legal     = 1'b1;
          dec_aluop = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal     = 1'b1;
          dec_aluop = {1'b1, funct3};
        end
      end
      OPC_OP_IMMW: begin
        dec_a    = rs1_data;
        dec_word = 1'b1;
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            dec_b = imm_i;
          end
          3'b001: begin
            legal     = (funct7 == 7'b0000000);
            dec_aluop = 4'b0001;
            dec_b     = shamt5;
          end
          3'b101: begin
            // funct7 check also enforces inst[25]=0 for the 5-bit shamt
            legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_aluop = {in_inst[30], 3'b101};
            dec_b     = shamt5;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal     = 1'b1;
        dec_aluop = 4'b1111;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        dec_a = in_pc;
        dec_b = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings still flow downstream, but as an inert bundle.
  assign aluop_next = legal ? dec_aluop : 4'b0000;
  assign a_next     = legal ? dec_a : '0;
  assign b_next     = legal ? dec_b : '0;
  assign word_next  = legal & dec_word;
  assign wen_next   = legal & (rd != 5'd0);

  logic            valid_reg;
  logic [3:0]      aluop_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [4:0]      rd_reg;
  logic            wen_reg;
  logic            word_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] pc_reg;
  logic            accept;

  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      aluop_reg   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rd_reg      <= '0;
      wen_reg     <= 1'b0;
      word_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      pc_reg      <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      aluop_reg   <= aluop_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      rd_reg      <= rd;
      wen_reg     <= wen_next;
      word_reg    <= word_next;
      illegal_reg <= !legal;
      pc_reg      <= in_pc;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_aluop   = aluop_reg;
  assign out_a       = a_reg;
  assign out_b       = b_reg;
  assign out_rd      = rd_reg;
  assign out_wen     = wen_reg;
  assign out_word    = word_reg;
  assign out_illegal = illegal_reg;
  assign out_pc      = pc_reg;

endmodule

// File: tb/tb_ysyx_220053_idu.sv
// Self-checking bench for ysyx_220053_idu: table of hand-decoded vectors fed
// through a scoreboard, plus backpressure, flush and reset-in-stall sequences.
module tb_ysyx_220053_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_word;
  logic        out_illegal;
  logic [63:0] out_pc;

  always #5 clk = ~clk;

  ysyx_220053_idu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
    .out_word(out_word), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  typedef struct packed {
    logic [3:0]  aluop;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        word;
    logic        illegal;
    logic [63:0] pc;
  } bundle_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] r1;
    logic [63:0] r2;
    bundle_t     exp;
  } vec_t;

  bundle_t dut_b;
  assign dut_b = {out_aluop, out_a, out_b, out_rd, out_wen, out_word, out_illegal, out_pc};

  bundle_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  vec_t    tbl[17];

  task automatic chk(input string nm, input logic [203:0] act, input logic [203:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] r1, input logic [63:0] r2,
                               input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic wen, input logic word,
                               input logic ill);
    vec_t v;
    v.inst = inst;
    v.pc   = pc;
    v.r1   = r1;
    v.r2   = r2;
    v.exp  = '{aluop: op, a: a, b: b, rd: rd, wen: wen, word: word, illegal: ill, pc: pc};
    return v;
  endfunction

  // Drive one instruction and wait for its handshake; pushes the expected bundle on accept.
  task automatic send(input vec_t v);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_pc    = v.pc;
    rs1_data = v.r1;
    rs2_data = v.r2;
    @(negedge clk);
    chk("rs_addr", {rs1_addr, rs2_addr}, {v.inst[19:15], v.inst[24:20]});
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 want 1 for inst %h", v.inst);
    end else begin
      @(posedge clk);
      exp_q.push_back(v.exp);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: ordered scoreboard compare plus latency, hold and flush checks.
  logic    acc_prev   = 1'b0;
  logic    flush_prev = 1'b0;
  logic    hold_prev  = 1'b0;
  bundle_t held;

  always @(negedge clk) begin
    if (acc_prev)   chk("latency_valid", out_valid, 1'b1);
    if (flush_prev) chk("flush_valid", out_valid, 1'b0);
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_stable", dut_b, held);
    end
    if (rst) begin
      acc_prev   <= 1'b0;
      flush_prev <= 1'b0;
      hold_prev  <= 1'b0;
    end else begin
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
      if (flush && out_valid) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bundle: got %h want none", dut_b);
        end else begin
          chk("bundle", dut_b, exp_q.pop_front());
        end
      end
      acc_prev   <= in_valid && in_ready && !flush;
      flush_prev <= flush;
      hold_prev  <= out_valid && !out_ready && !flush;
      held       <= dut_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv(32'h002081B3, 64'h1000, 64'd5, 64'd7, 4'h0, 64'd5, 64'd7, 5'd3, 1, 0, 0);
    tbl[1]  = mkv(32'h43F35293, 64'h1004, 64'h8000000000000000, 64'h1234,
                  4'hD, 64'h8000000000000000, 64'h3F, 5'd5, 1, 0, 0);
    tbl[2]  = mkv(32'h800000B7, 64'h1008, 64'hAAAA, 64'hBBBB,
                  4'hF, 64'h0, 64'hFFFFFFFF80000000, 5'd1, 1, 0, 0);
    tbl[3]  = mkv(32'h4020803B, 64'h100C, 64'd10, 64'd3, 4'h8, 64'd10, 64'd3, 5'd0, 0, 1, 0);
    tbl[4]  = mkv(32'h0200909B, 64'h1010, 64'hFF, 64'h1, 4'h0, 64'h0, 64'h0, 5'd1, 0, 0, 1);
    tbl[5]  = mkv(32'h02208133, 64'h1014, 64'd6, 64'd7, 4'h0, 64'h0, 64'h0, 5'd2, 0, 0, 1);
    tbl[6]  = mkv(32'h12345217, 64'h80000000, 64'h55, 64'h66,
                  4'h0, 64'h80000000, 64'h12345000, 5'd4, 1, 0, 0);
    tbl[7]  = mkv(32'hFFF40393, 64'h101C, 64'h100, 64'h0,
                  4'h0, 64'h100, 64'hFFFFFFFFFFFFFFFF, 5'd7, 1, 0, 0);
    tbl[8]  = mkv(32'h00553493, 64'h1020, 64'd3, 64'd9, 4'h3, 64'd3, 64'd5, 5'd9, 1, 0, 0);
    tbl[9]  = mkv(32'h40D655B3, 64'h1024, 64'hFFFFFFFF00000000, 64'd4,
                  4'hD, 64'hFFFFFFFF00000000, 64'd4, 5'd11, 1, 0, 0);
    tbl[10] = mkv(32'h003170B3, 64'h1028, 64'hF0F0, 64'hFF00, 4'h7, 64'hF0F0, 64'hFF00, 5'd1, 1, 0, 0);
    tbl[11] = mkv(32'h40009093, 64'h102C, 64'd1, 64'd2, 4'h0, 64'h0, 64'h0, 5'd1, 0, 0, 1);
    tbl[12] = mkv(32'h41F1D11B, 64'h1030, 64'h80000000, 64'd2,
                  4'hD, 64'h80000000, 64'h1F, 5'd2, 1, 1, 0);
    tbl[13] = mkv(32'h007312BB, 64'h1034, 64'd1, 64'h28, 4'h1, 64'd1, 64'h28, 5'd5, 1, 1, 0);
    tbl[14] = mkv(32'h007362BB, 64'h1038, 64'd1, 64'h28, 4'h0, 64'h0, 64'h0, 5'd5, 0, 0, 1);
    tbl[15] = mkv(32'h00003083, 64'h103C, 64'd9, 64'd9, 4'h0, 64'h0, 64'h0, 5'd1, 0, 0, 1);
    tbl[16] = mkv(32'h03F09013, 64'h1040, 64'd1, 64'd0, 4'h1, 64'd1, 64'h3F, 5'd0, 0, 0, 0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_bundle", dut_b, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back stream of every table vector.
    for (int i = 0; i < 17; i++) send(tbl[i]);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: stall three cycles with a second instruction waiting.
    send(tbl[0]);
    out_ready = 1'b0;
    fork
      send(tbl[1]);
      begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Flush while a bundle is held and another instruction handshakes.
    send(tbl[2]);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = tbl[3].inst;
    in_pc    = tbl[3].pc;
    rs1_data = tbl[3].r1;
    rs2_data = tbl[3].r2;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    @(posedge clk);
    #1;
    send(tbl[8]);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset pulse during a stall.
    send(tbl[6]);
    out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_bundle", dut_b, '0);
    chk("rst_stall_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(tbl[13]);
    idle();
    repeat (3) @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
